// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer.
package demux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 4;

endpackage : demux_pkg

// File: rtl/demux_fifo.sv
// First-word fall-through FIFO with occupancy count; storage is cleared on reset.
module demux_fifo
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Full and empty come straight from the registered count, so pop never
    // feeds back into push acceptance in the same cycle.
    assign full      = (count == CW'(DEPTH));
    assign valid     = (count != CW'(0));
    assign head_data = mem[rd_ptr];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && valid;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : demux_fifo

// File: rtl/demux_1to2_stream.sv
// Routes each accepted input word into FIFO A or B according to in_sel.
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         a_data,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic [WIDTH-1:0]         b_data,
    output logic                     b_valid,
    input  logic                     b_ready,
    output logic [$clog2(DEPTH):0]   a_count,
    output logic [$clog2(DEPTH):0]   b_count
);

    logic a_full;
    logic b_full;
    logic a_push;
    logic b_push;
    logic accept;

    // Only in_sel reaches in_ready combinationally; full flags are registered.
    assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;
    assign accept   = in_valid && in_ready;
    assign a_push   = accept && (in_sel == SEL_A);
    assign b_push   = accept && (in_sel == SEL_B);

    // Output A queue.
    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_push),
        .push_data (in_data),
        .pop       (a_ready),
        .head_data (a_data),
        .valid     (a_valid),
        .full      (a_full),
        .count     (a_count)
    );

    // Output B queue.
    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_data (in_data),
        .pop       (b_ready),
        .head_data (b_data),
        .valid     (b_valid),
        .full      (b_full),
        .count     (b_count)
    );

endmodule : demux_1to2_stream

// File: doc/demux_1to2_stream.md
# demux_1to2_stream

Stream demultiplexer that routes 16-bit words from one producer to one of two consumers under valid/ready handshakes. It performs the inverse of the team's 2-to-1 datapath mux: `in_sel == 0` routes to output A, `in_sel == 1` routes to output B. It sits between a single upstream source and two independent downstream sinks. Each sink has its own FIFO, so a stalled sink never blocks traffic bound for the other.

## Interface
- `WIDTH`, 16, data width in bits.
- `DEPTH`, 4, entries per output FIFO; must be a power of 2 and ≥ 2.
- `clk`  input  1  sole clock; all logic is on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_data`  input  WIDTH  word offered by the producer.
- `in_sel`  input  1  destination select: 0 = A, 1 = B.
- `in_valid`  input  1  producer has a word on `in_data`/`in_sel`.
- `in_ready`  output  1  the block accepts the word this cycle.
- `a_data`  output  WIDTH  head word of FIFO A.
- `a_valid`  output  1  FIFO A is non-empty.
- `a_ready`  input  1  consumer A takes the head word.
- `b_data`  output  WIDTH  head word of FIFO B.
- `b_valid`  output  1  FIFO B is non-empty.
- `b_ready`  input  1  consumer B takes the head word.
- `a_count`  output  $clog2(DEPTH)+1  occupancy of FIFO A.
- `b_count`  output  $clog2(DEPTH)+1  occupancy of FIFO B.

## Operation
- **Input handshake.**
  - `in_ready = in_sel ? !b_full : !a_full`, computed combinationally from `in_sel` and the registered full flags.
  - A transfer occurs when `in_valid && in_ready`.
  - The producer holds `in_data` and `in_sel` stable while `in_valid` is high and `in_ready` is low.
- **Routing.** An accepted word is pushed only into the FIFO selected by `in_sel`. The other FIFO is untouched.
- **Output handshake.**
  - A pop occurs when `x_valid && x_ready`.
  - `x_data` is valid only while `x_valid` is high.
  - `x_data` is driven from the FIFO storage at the read pointer (first-word fall-through).
- **Ordering.** Words are delivered in acceptance order within each output. No ordering is defined across A and B.
- **Full FIFO.**
  - `in_ready` stays 0 for words targeting a full FIFO, even if that FIFO pops in the same cycle. There is no same-cycle bypass.
  - Words targeting the other FIFO are still accepted.
- **Empty FIFO.**
  - `x_valid` is 0.
  - `x_ready` is ignored, and `x_count` never underflows.
- **Simultaneous push and pop on the same FIFO** (only possible when it is not full): the count is unchanged and both pointers advance.
- **Pointers.** Read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. `full` is `count == DEPTH`; `empty` is `count == 0`.
- **Reset.** Asserting `rst` at any time immediately:
  - empties both FIFOs, zeroing pointers and counts;
  - forces `a_valid = b_valid = 0`;
  - discards in-flight words.

  During reset, `in_ready` evaluates to 1, but no push occurs while `rst` is high.
- **Reset values.**
  - `a_valid`, `b_valid` = 0.
  - `a_count`, `b_count` = 0.
  - `a_data`, `b_data` = 0, because storage is cleared on reset.

## Timing
- **Latency.** A word accepted at edge N appears with `x_valid = 1` after edge N (visible in cycle N+1). Minimum input-to-output latency is 1 cycle.
- **Throughput.** One word per cycle into each FIFO while it is not full. Sustained 1 word/cycle per output when `x_ready` is held high.
- **Counts.** `x_count` updates on the same edge as the push or pop that changes it.
- **Combinational paths.** The only combinational input-to-output path is `in_sel` → `in_ready`. No path exists from `x_ready` to `in_ready` or to `x_valid`.

## Structure
- **Package `demux_pkg`:**
  - `SEL_A = 1'b0`, `SEL_B = 1'b1`;
  - `DEFAULT_WIDTH = 16`, `DEFAULT_DEPTH = 4`.
- **Sub-module `demux_fifo`:**
  - synchronous FWFT FIFO, parameterised by WIDTH and DEPTH;
  - ports: `clk`, `rst`, `push`, `push_data`, `pop`, `head_data`, `valid`, `full`, `count`;
  - instantiated twice.
- **Top level:** `in_ready` logic and push/pop decode only.

## Test plan
- **Reset state.** Assert `rst` mid-stream with A holding 2 words → `a_valid = 0`, `a_count = 0`, `a_data = 16'h0000` asynchronously; `in_ready = 1` after release.
- **Basic routing.** Send 16'h1111 (sel 0) then 16'h2222 (sel 1) with both readies high → `a_data = 16'h1111` in cycle 1, `b_data = 16'h2222` in cycle 2; each `x_valid` pulses for one cycle.
- **Full A does not block B.** Hold `a_ready = 0` and push 4 words to A → `a_count = 4`; a 5th word with sel 0 sees `in_ready = 0`; switching to sel 1 with 16'hBEEF → accepted, `b_valid = 1` next cycle.
- **No bypass on full.** With A full, drive `a_ready = 1` and an A-bound word in the same cycle → `in_ready = 0`; `a_count` drops to 3; the word is accepted the next cycle and `a_count` returns to 4.
- **Wrap-around and ordering.** Stream 16'h0000 through 16'h0009 to B with `b_ready` toggling 1-0-1-0 → B emits 0..9 in order; `b_count` never exceeds 4 and never underflows.
- **Simultaneous push and pop.** B holds 2 words; push and pop B in the same cycle → `b_count` stays 2 and the head advances to the next word.
